// File: rtl/ssd_scan_n.sv
// Multiplexed N-digit seven-segment scanner with double-buffered display data,
// leading-zero blanking and per-digit blinking. Outputs are active-low.
module ssd_scan_n #(
    parameter int N_DIGITS   = 4,
    parameter int DIV_BITS   = 19,
    parameter int BLINK_BITS = 25,
    parameter int HEX        = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   digits,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [N_DIGITS-1:0]     blink_en,
    input  logic                    blank_lz,
    output logic                    upd_ack,
    output logic [7:0]              ssd,
    output logic [N_DIGITS-1:0]     ssd_ctl
);

    localparam int                  PW      = $clog2(N_DIGITS);
    localparam logic [PW-1:0]       LAST    = PW'(N_DIGITS - 1);
    localparam logic [DIV_BITS-1:0] DIV_MAX = '1;

    logic [DIV_BITS-1:0]   div;
    logic [PW-1:0]         ptr;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                  tick;
    logic                  frame;

    logic [4*N_DIGITS-1:0] sh_digits, act_digits;
    logic [N_DIGITS-1:0]   sh_dp, act_dp;
    logic [N_DIGITS-1:0]   sh_blink, act_blink;
    logic                  sh_blz, act_blz;
    logic                  pending;

    logic [3:0]            cur_code;
    logic                  cur_dp;
    logic                  cur_blink;
    logic                  cur_lz;
    logic                  zero_run;
    logic [N_DIGITS-1:0]   ctl_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        if (HEX == 0 && code > 4'h9) begin
            seg = 7'b1111111;
        end
        return seg;
    endfunction

    assign tick  = (div == DIV_MAX);
    assign frame = tick && (ptr == LAST);

    // Scan timing: dwell divider, digit pointer, blink counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div       <= '0;
            ptr       <= '0;
            blink_cnt <= '0;
        end else begin
            div       <= div + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
            if (tick) begin
                ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
            end
        end
    end

    // Shadow/active buffers; active only ever changes on the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digits  <= '0;
            sh_dp      <= '0;
            sh_blink   <= '0;
            sh_blz     <= 1'b0;
            pending    <= 1'b0;
            act_digits <= '0;
            act_dp     <= '0;
            act_blink  <= '0;
            act_blz    <= 1'b0;
            upd_ack    <= 1'b0;
        end else begin
            upd_ack <= frame && (load || pending);
            if (load && frame) begin
                act_digits <= digits;
                act_dp     <= dp;
                act_blink  <= blink_en;
                act_blz    <= blank_lz;
                pending    <= 1'b0;
            end else if (load) begin
                sh_digits <= digits;
                sh_dp     <= dp;
                sh_blink  <= blink_en;
                sh_blz    <= blank_lz;
                pending   <= 1'b1;
            end else if (frame && pending) begin
                act_digits <= sh_digits;
                act_dp     <= sh_dp;
                act_blink  <= sh_blink;
                act_blz    <= sh_blz;
                pending    <= 1'b0;
            end
        end
    end

    // zero_run accumulates left to right: it stays high while every digit so far is 0
    always_comb begin
        cur_code  = '0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_lz    = 1'b0;
        zero_run  = 1'b1;
        ctl_next  = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            zero_run = zero_run && (act_digits[4*i +: 4] == 4'd0);
            if (ptr == PW'(i)) begin
                cur_code              = act_digits[4*i +: 4];
                cur_dp                = act_dp[i];
                cur_blink             = act_blink[i];
                cur_lz                = zero_run && (i != N_DIGITS - 1);
                ctl_next[N_DIGITS-1-i] = 1'b0;
            end
        end
    end

    // Output register: one cycle behind ptr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssd     <= 8'hFF;
            ssd_ctl <= '1;
        end else begin
            ssd_ctl <= ctl_next;
            if (cur_blink && blink_cnt[BLINK_BITS-1]) begin
                ssd <= 8'hFF;
            end else if (act_blz && cur_lz) begin
                ssd <= 8'hFF;
            end else begin
                ssd <= {~cur_dp, seg_decode(cur_code)};
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_n.sv
// Bench for ssd_scan_n (N=4, DIV_BITS=2, BLINK_BITS=4, HEX=0): directed plus
// randomized loads compared against a frame-level model of what should be shown.
module tb_ssd_scan_n;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blink_en;
    logic        blank_lz;
    logic        upd_ack;
    logic [7:0]  ssd;
    logic [3:0]  ssd_ctl;

    always #5 clk = ~clk;

    ssd_scan_n #(
        .N_DIGITS  (4),
        .DIV_BITS  (2),
        .BLINK_BITS(4),
        .HEX       (0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .digits  (digits),
        .dp      (dp),
        .blink_en(blink_en),
        .blank_lz(blank_lz),
        .upd_ack (upd_ack),
        .ssd     (ssd),
        .ssd_ctl (ssd_ctl)
    );

    int n_cmp = 0;
    int n_err = 0;
    int e     = 0;   // rising edges since reset release
    int n_ack = 0;

    // model: data on display (a_*), data waiting (s_*), pending flag
    logic [15:0] a_dg, s_dg;
    logic [3:0]  a_dp, s_dp, a_bl, s_bl;
    logic        a_lz, s_lz, pend;

    function automatic logic [6:0] seg7(input logic [3:0] code);
        case (code)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7:0] model_ssd(input int k, input logic ph);
        logic allz;
        allz = 1'b1;
        if (a_bl[k] && ph) return 8'hFF;
        for (int j = 0; j <= k; j++) begin
            if (a_dg[4*j +: 4] != 4'd0) allz = 1'b0;
        end
        if (a_lz && k < 3 && allz) return 8'hFF;
        return {~a_dp[k], seg7(a_dg[4*k +: 4])};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic model_reset();
        e = 0;
        a_dg = '0; a_dp = '0; a_bl = '0; a_lz = 1'b0;
        s_dg = '0; s_dp = '0; s_bl = '0; s_lz = 1'b0;
        pend = 1'b0;
    endtask

    task automatic step(input logic ld, input logic [15:0] dg, input logic [3:0] dv,
                        input logic [3:0] bv, input logic lv);
        int k;
        logic ph, fr, x_ack;
        logic [7:0] x_ssd;
        logic [3:0] x_ctl;
        load = ld; digits = dg; dp = dv; blink_en = bv; blank_lz = lv;
        k     = (e / 4) % 4;
        ph    = (e % 16) >= 8;
        x_ssd = model_ssd(k, ph);
        x_ctl = ~(4'b1000 >> k);
        fr    = ((e + 1) % 16 == 0);
        x_ack = fr && (ld || pend);
        if (ld && fr) begin
            a_dg = dg; a_dp = dv; a_bl = bv; a_lz = lv; pend = 1'b0;
        end else if (ld) begin
            s_dg = dg; s_dp = dv; s_bl = bv; s_lz = lv; pend = 1'b1;
        end else if (fr && pend) begin
            a_dg = s_dg; a_dp = s_dp; a_bl = s_bl; a_lz = s_lz; pend = 1'b0;
        end
        @(posedge clk);
        e++;
        #1;
        chk("ssd", ssd, x_ssd);
        chk("ssd_ctl", {4'h0, ssd_ctl}, {4'h0, x_ctl});
        chk("upd_ack", {7'h0, upd_ack}, {7'h0, x_ack});
        if (upd_ack === 1'b1) n_ack++;
        load = 1'b0;
    endtask

    // idle cycles drive garbage on the data inputs; without load it must be ignored
    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic idle_until(input int m);
        while (e % 16 != m) idle(1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ssd"}, ssd, 8'hFF);
        chk({tag, "_ctl"}, {4'h0, ssd_ctl}, 8'h0F);
        chk({tag, "_ack"}, {7'h0, upd_ack}, 8'h00);
    endtask

    initial begin
        logic [15:0] rd;
        rst_n = 1'b0; load = 1'b0; digits = '0; dp = '0; blink_en = '0; blank_lz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        model_reset();

        // free-running scan with all-zero data
        idle(40);

        // mid-frame load with a decimal point on digit 1
        idle_until(2);
        step(1'b1, 16'h4321, 4'b0010, 4'b0000, 1'b0);
        idle(16);
        idle_until(6);
        chk("digit1_dp", ssd, 8'h24);
        idle(20);

        // two loads in one frame: only the last is shown, one acknowledge
        idle_until(1);
        n_ack = 0;
        step(1'b1, 16'h1111, 4'b0000, 4'b0000, 1'b0);
        idle(3);
        step(1'b1, 16'h2222, 4'b0000, 4'b0000, 1'b0);
        idle(26);
        chk("double_load_acks", 8'(n_ack), 8'd1);
        idle_until(2);
        chk("double_load_d0", ssd, 8'hA4);

        // leading-zero blanking
        idle_until(1);
        step(1'b1, 16'h0500, 4'b0000, 4'b0000, 1'b1);
        idle(16);
        idle_until(2);
        chk("lz_digit0", ssd, 8'hFF);
        idle_until(10);
        chk("lz_digit2", ssd, 8'h92);
        idle_until(14);
        chk("lz_digit3", ssd, 8'hC0);
        step(1'b1, 16'h0000, 4'b0000, 4'b0000, 1'b1);
        idle(40);

        // blinking digit 0: blank hex code, then a numeral
        idle_until(1);
        step(1'b1, 16'h000C, 4'b0000, 4'b0001, 1'b0);
        idle(16);
        idle_until(2);
        chk("blink_code12", ssd, 8'hFF);
        step(1'b1, 16'h0003, 4'b0000, 4'b0001, 1'b0);
        idle(16);
        idle_until(2);
        chk("blink_code3", ssd, 8'hB0);
        step(1'b1, 16'h5555, 4'b0000, 4'b1100, 1'b0);
        idle(40);

        // load landing exactly on the frame boundary bypasses the shadow
        idle_until(15);
        step(1'b1, 16'h8765, 4'b1001, 4'b0000, 1'b0);
        idle(20);

        // randomized loads, zero-biased digits for blanking coverage
        for (int i = 0; i < 600; i++) begin
            rd = '0;
            for (int j = 0; j < 4; j++) begin
                rd[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                step(1'b1, rd, 4'($urandom),
                     ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, 1'($urandom));
            end else begin
                idle(1);
            end
        end

        // asynchronous reset with data pending
        idle_until(6);
        step(1'b1, 16'h9876, 4'hF, 4'h0, 1'b0);
        idle(2);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        chk_reset_outputs("held_reset");
        rst_n = 1'b1;
        model_reset();
        n_ack = 0;
        idle(40);
        chk("post_reset_acks", 8'(n_ack), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
